// File: rtl/bomb_pkg.sv
// Shared types and widths for the bomb detonator game controller.
// State encodings match the 2-bit state output seen by display logic.
package bomb_pkg;

    localparam int SEC_W = 7;
    localparam int IDX_W = 3;
    localparam int ERR_W = 2;
    localparam int KEY_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ARMED     = 2'b01,
        ST_DEFUSED   = 2'b10,
        ST_DETONATED = 2'b11
    } state_e;

    // Index of the highest set key bit; only meaningful for one-hot input.
    function automatic logic [1:0] key_index(input logic [KEY_N-1:0] k);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < KEY_N; i++) begin
            if (k[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Countdown prescaler: counts 0..CLK_DIV-1 while enabled, held at 0 otherwise.
// tick is high during the terminal-count cycle; the owner registers it.
module tick_prescaler
    import bomb_pkg::*;
#(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic async_reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = enable && (cnt_q == TERM);

    // Next count: wrap at terminal count, park at 0 when idle or cleared.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || !enable || tick) cnt_d = '0;
    end

    // Count register.
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) cnt_q <= '0;
        else              cnt_q <= cnt_d;
    end

endmodule

// File: rtl/bomb_sequencer.sv
// Game controller: arming, seconds countdown, code entry, final outcome.
// Timer expiry beats a simultaneous final digit or error.
module bomb_sequencer
    import bomb_pkg::*;
#(
    parameter int                    CLK_DIV     = 50_000_000,
    parameter int                    COUNT_START = 30,
    parameter int                    CODE_LEN    = 4,
    parameter logic [2*CODE_LEN-1:0] DEFUSE_CODE = 8'b11_10_01_00,
    parameter int                    MAX_ERRORS  = 3
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic             arm_pulse,
    input  logic [KEY_N-1:0] key_pulse,
    output logic [1:0]       state,
    output logic [SEC_W-1:0] seconds_left,
    output logic [IDX_W-1:0] entry_idx,
    output logic [ERR_W-1:0] error_count,
    output logic             tick
);

    localparam logic [SEC_W-1:0] SEC_START = SEC_W'(COUNT_START);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CODE_LEN - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = ERR_W'(MAX_ERRORS);

    state_e           state_q, state_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             tick_q, tick_d;

    logic                  pre_tick;
    logic                  arm_clr;
    logic                  good_key;
    logic [ERR_W-1:0]      err_inc;
    logic [2*CODE_LEN-1:0] code_sh;
    logic [1:0]            digit;

    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk         (clk),
        .async_reset (async_reset),
        .clear       (arm_clr),
        .enable      (state_q == ST_ARMED),
        .tick        (pre_tick)
    );

    // Current expected digit and classification of this cycle's key press.
    always_comb begin
        code_sh  = DEFUSE_CODE >> {idx_q, 1'b0};
        digit    = code_sh[1:0];
        good_key = $onehot(key_pulse) && (key_index(key_pulse) == digit);
        err_inc  = (err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);
    end

    // Next-state and counter updates for the game FSM.
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        idx_d   = idx_q;
        err_d   = err_q;
        tick_d  = 1'b0;
        arm_clr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arm_pulse) begin
                    state_d = ST_ARMED;
                    sec_d   = SEC_START;
                    idx_d   = '0;
                    err_d   = '0;
                    arm_clr = 1'b1;
                end
            end
            ST_ARMED: begin
                tick_d = pre_tick;
                if (pre_tick && sec_q != '0) sec_d = sec_q - SEC_W'(1);
                if (key_pulse != '0) begin
                    if (good_key) begin
                        if (idx_q == IDX_LAST) state_d = ST_DEFUSED;
                        else                   idx_d   = idx_q + IDX_W'(1);
                    end else begin
                        idx_d = '0;
                        err_d = err_inc;
                        if (err_inc == ERR_MAX) state_d = ST_DETONATED;
                    end
                end
                if (pre_tick && sec_q == SEC_W'(1)) state_d = ST_DETONATED;
            end
            ST_DEFUSED, ST_DETONATED: begin
                if (arm_pulse) begin
                    state_d = ST_IDLE;
                    sec_d   = SEC_START;
                    idx_d   = '0;
                    err_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered state and outputs.
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            state_q <= ST_IDLE;
            sec_q   <= SEC_START;
            idx_q   <= '0;
            err_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            tick_q  <= tick_d;
        end
    end

    assign state        = state_q;
    assign seconds_left = sec_q;
    assign entry_idx    = idx_q;
    assign error_count  = err_q;
    assign tick         = tick_q;

endmodule

// File: tb/tb_bomb_sequencer.sv
// Self-checking bench for bomb_sequencer: directed scenarios then random
// traffic, compared cycle by cycle against a behavioural game model.
module tb_bomb_sequencer;

    localparam int CLK_DIV     = 4;
    localparam int COUNT_START = 5;
    localparam int CODE_LEN    = 4;
    localparam int MAX_ERRORS  = 3;

    logic       clk = 1'b0;
    logic       async_reset;
    logic       arm_pulse;
    logic [3:0] key_pulse;
    logic [1:0] state;
    logic [6:0] seconds_left;
    logic [2:0] entry_idx;
    logic [1:0] error_count;
    logic       tick;

    int checks   = 0;
    int failures = 0;

    // Behavioural model of the game
    int code [CODE_LEN] = '{0, 1, 2, 3};
    int m_state, m_sec, m_idx, m_err, m_tick, m_elapsed;

    bomb_sequencer #(
        .CLK_DIV     (CLK_DIV),
        .COUNT_START (COUNT_START),
        .CODE_LEN    (CODE_LEN),
        .DEFUSE_CODE (8'b11_10_01_00),
        .MAX_ERRORS  (MAX_ERRORS)
    ) dut (
        .clk          (clk),
        .async_reset  (async_reset),
        .arm_pulse    (arm_pulse),
        .key_pulse    (key_pulse),
        .state        (state),
        .seconds_left (seconds_left),
        .entry_idx    (entry_idx),
        .error_count  (error_count),
        .tick         (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_state"}, int'(state), m_state);
        chk({tag, "_sec"},   int'(seconds_left), m_sec);
        chk({tag, "_idx"},   int'(entry_idx), m_idx);
        chk({tag, "_err"},   int'(error_count), m_err);
        chk({tag, "_tick"},  int'(tick), m_tick);
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_sec     = COUNT_START;
        m_idx     = 0;
        m_err     = 0;
        m_tick    = 0;
        m_elapsed = 0;
    endtask

    // One clock edge of the game rules
    task automatic model_step(input bit arm, input logic [3:0] key);
        bit boom, done;
        boom = 0;
        done = 0;
        m_tick = 0;
        case (m_state)
            0: if (arm) begin
                m_state = 1; m_sec = COUNT_START;
                m_idx = 0; m_err = 0; m_elapsed = 0;
            end
            1: begin
                m_elapsed++;
                if (m_elapsed % CLK_DIV == 0) begin
                    m_tick = 1;
                    m_sec = m_sec - 1;
                    if (m_sec == 0) boom = 1;
                end
                if (key != 0) begin
                    if ($countones(key) == 1 && int'(key) == (1 << code[m_idx])) begin
                        if (m_idx == CODE_LEN - 1) done = 1;
                        else m_idx++;
                    end else begin
                        m_idx = 0;
                        if (m_err < MAX_ERRORS) m_err++;
                        if (m_err == MAX_ERRORS) boom = 1;
                    end
                end
                if (boom) m_state = 3;
                else if (done) m_state = 2;
            end
            default: if (arm) begin
                m_state = 0; m_sec = COUNT_START; m_idx = 0; m_err = 0;
            end
        endcase
    endtask

    task automatic cyc(input bit arm, input logic [3:0] key);
        @(negedge clk);
        arm_pulse = arm;
        key_pulse = key;
        @(posedge clk);
        model_step(arm, key);
        #1;
        chk_all("cyc");
    endtask

    task automatic do_reset();
        @(negedge clk);
        arm_pulse = 0;
        key_pulse = 0;
        #2 async_reset = 0;
        #1 model_reset();
        chk_all("rst");
        @(negedge clk);
        async_reset = 1;
    endtask

    initial begin
        logic [3:0] k;
        int r;
        async_reset = 0;
        arm_pulse   = 0;
        key_pulse   = 0;
        model_reset();
        #7 chk_all("por");
        @(negedge clk);
        async_reset = 1;

        // Countdown to detonation
        cyc(1, 0);
        chk("s1_armed", int'(state), 1);
        chk("s1_sec", int'(seconds_left), 5);
        repeat (20) cyc(0, 0);
        chk("s1_det", int'(state), 3);
        chk("s1_sec0", int'(seconds_left), 0);
        cyc(1, 0);

        // Correct code defuses
        cyc(1, 0);
        cyc(0, 4'b0001);
        cyc(0, 4'b0010);
        cyc(0, 4'b0100);
        chk("s2_idx3", int'(entry_idx), 3);
        cyc(0, 4'b1000);
        chk("s2_def", int'(state), 2);
        repeat (6) cyc(0, 0);
        chk("s2_tick0", int'(tick), 0);
        chk("s2_frozen", int'(seconds_left), 4);
        cyc(1, 0);

        // Wrong digits detonate
        cyc(1, 0);
        cyc(0, 4'b0001);
        cyc(0, 4'b0010);
        cyc(0, 4'b1000);
        chk("s3_idx0", int'(entry_idx), 0);
        chk("s3_err1", int'(error_count), 1);
        cyc(0, 4'b0100);
        cyc(0, 4'b0100);
        chk("s3_err3", int'(error_count), 3);
        chk("s3_det", int'(state), 3);
        cyc(1, 0);
        chk("s3_idle", int'(state), 0);
        cyc(1, 0);
        chk("s3_rearm", int'(state), 1);

        // Simultaneous keys count as an error
        cyc(0, 4'b0011);
        chk("s4_idx", int'(entry_idx), 0);
        chk("s4_err", int'(error_count), 1);
        do_reset();

        // Final digit on the terminal tick: timer wins
        cyc(1, 0);
        cyc(0, 4'b0001);
        cyc(0, 4'b0010);
        cyc(0, 4'b0100);
        repeat (16) cyc(0, 0);
        cyc(0, 4'b1000);
        chk("s5_det", int'(state), 3);
        chk("s5_sec", int'(seconds_left), 0);
        cyc(1, 0);

        // Reset mid-countdown
        cyc(1, 0);
        cyc(0, 4'b0001);
        cyc(0, 4'b0010);
        repeat (7) cyc(0, 0);
        chk("s6_sec3", int'(seconds_left), 3);
        chk("s6_idx2", int'(entry_idx), 2);
        do_reset();
        chk("s6_rst_state", int'(state), 0);
        chk("s6_rst_sec", int'(seconds_left), 5);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            r = int'($urandom_range(0, 9));
            if (r < 5) k = 4'b0000;
            else if (r < 8 && m_state == 1) k = 4'(1 << code[m_idx]);
            else k = 4'($urandom_range(1, 15));
            cyc($urandom_range(0, 99) < 4, k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
